// File: rtl/tone_decoder_pkg.sv
// Shared definitions for the tone decoder: direction codes, FSM states and band indices.
// Direction codes are the ones the drive state machine expects on tdDir.
package tone_decoder_pkg;

  localparam logic [1:0] DIR_STRAIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT     = 2'b01;
  localparam logic [1:0] DIR_RIGHT    = 2'b10;
  localparam logic [1:0] DIR_BACK     = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    VALID   = 2'd2,
    REARM   = 2'd3
  } state_t;

  localparam int         NUM_BANDS = 5;
  localparam logic [2:0] BAND_1    = 3'd0;
  localparam logic [2:0] BAND_2    = 3'd1;
  localparam logic [2:0] BAND_3    = 3'd2;
  localparam logic [2:0] BAND_4    = 3'd3;
  localparam logic [2:0] BAND_5    = 3'd4;

  // Band 5 is the stop tone and carries no direction, so it reports STRAIGHT.
  function automatic logic [1:0] band_dir(input logic [2:0] band);
    case (band)
      BAND_1:  band_dir = DIR_STRAIGHT;
      BAND_2:  band_dir = DIR_LEFT;
      BAND_3:  band_dir = DIR_RIGHT;
      BAND_4:  band_dir = DIR_BACK;
      default: band_dir = DIR_STRAIGHT;
    endcase
  endfunction

endpackage

// File: rtl/tone_band_counter.sv
// One band channel: 2-flop synchronizer, rising-edge detect, saturating edge counter
// and a present flag judged against the MIN/MAX edge limits.
module tone_band_counter #(
  parameter int MIN_EDGES = 5,
  parameter int MAX_EDGES = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic bp,
  input  logic clear,
  output logic present
);

  localparam int EW = $clog2(MAX_EDGES + 2);

  logic          sync1;
  logic          sync2;
  logic          sync_prev;
  logic          edge_det;
  logic [EW-1:0] count;
  logic [EW-1:0] count_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= bp;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign edge_det = sync2 & ~sync_prev;

  // count_next folds in this cycle's edge so the window judgement sees it.
  always_comb begin
    count_next = count;
    if (edge_det && (count != EW'(MAX_EDGES + 1))) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign present = (count_next >= EW'(MIN_EDGES)) && (count_next <= EW'(MAX_EDGES));

endmodule

// File: rtl/tone_decoder.sv
// Turns five band-pass comparator outputs into a confirmed junction command
// (tdEn/tdDir or tdStop) held until the drive state machine pulses tdAck.
module tone_decoder
  import tone_decoder_pkg::*;
#(
  parameter int GATE_CYCLES     = 500_000,
  parameter int MIN_EDGES       = 5,
  parameter int MAX_EDGES       = 200,
  parameter int CONFIRM_WINDOWS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  input  logic       tdAck,
  output logic       tdEn,
  output logic [1:0] tdDir,
  output logic       tdStop,
  output state_t     dbg_state
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int CW = $clog2(CONFIRM_WINDOWS + 1);

  logic [NUM_BANDS-1:0] bp_vec;
  logic [NUM_BANDS-1:0] present;
  logic [GW-1:0]        gate;
  logic                 eval;
  logic [2:0]           n_present;
  logic [2:0]           win_band;
  logic                 win_valid;

  state_t               state;
  logic [2:0]           cand;
  logic [CW-1:0]        confirm_cnt;
  logic                 rearm_armed;

  assign bp_vec = {bp5, bp4, bp3, bp2, bp1};

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
    tone_band_counter #(
      .MIN_EDGES (MIN_EDGES),
      .MAX_EDGES (MAX_EDGES)
    ) u_band (
      .clk     (clk),
      .rst     (rst),
      .bp      (bp_vec[g]),
      .clear   (eval),
      .present (present[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate <= '0;
    end else if (eval) begin
      gate <= '0;
    end else begin
      gate <= gate + 1'b1;
    end
  end

  assign eval = (gate == GW'(GATE_CYCLES - 1));

  // Exactly one present band is a candidate; zero or several count as no tone.
  always_comb begin
    n_present = '0;
    win_band  = BAND_1;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (present[i]) begin
        n_present = n_present + 1'b1;
        win_band  = 3'(i);
      end
    end
  end

  assign win_valid = (n_present == 3'd1);

  // rearm_armed records that a window boundary has passed inside REARM, so the
  // NONE result that releases it always comes from a complete window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= BAND_1;
      confirm_cnt <= '0;
      rearm_armed <= 1'b0;
      tdEn        <= 1'b0;
      tdDir       <= DIR_STRAIGHT;
      tdStop      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (eval && win_valid) begin
            cand        <= win_band;
            confirm_cnt <= CW'(1);
            if (CONFIRM_WINDOWS == 1) begin
              state  <= VALID;
              tdEn   <= (win_band != BAND_5);
              tdStop <= (win_band == BAND_5);
              tdDir  <= band_dir(win_band);
            end else begin
              state <= CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (eval) begin
            if (!win_valid) begin
              state       <= IDLE;
              confirm_cnt <= '0;
            end else if (win_band != cand) begin
              cand        <= win_band;
              confirm_cnt <= CW'(1);
            end else if ((confirm_cnt + 1'b1) >= CW'(CONFIRM_WINDOWS)) begin
              state       <= VALID;
              confirm_cnt <= '0;
              tdEn        <= (win_band != BAND_5);
              tdStop      <= (win_band == BAND_5);
              tdDir       <= band_dir(win_band);
            end else begin
              confirm_cnt <= confirm_cnt + 1'b1;
            end
          end
        end
        VALID: begin
          if (tdAck) begin
            state       <= REARM;
            rearm_armed <= eval;
            tdEn        <= 1'b0;
            tdStop      <= 1'b0;
            tdDir       <= DIR_STRAIGHT;
          end
        end
        REARM: begin
          if (eval) begin
            rearm_armed <= 1'b1;
            if (rearm_armed && !win_valid) begin
              state       <= IDLE;
              rearm_armed <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: directed tone patterns, expected command events queued
// with their cycle stamps and matched by an independent monitor.
module tb_tone_decoder;
  import tone_decoder_pkg::*;

  localparam int GATE = 1000;
  localparam int W    = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] bpv = '0;
  logic       tdAck = 1'b0;
  logic       tdEn;
  logic [1:0] tdDir;
  logic       tdStop;
  state_t     dbg_state;

  int unsigned cyc;
  int          checks = 0;
  int          failures = 0;
  int          per[5];
  int          ph[5];
  logic [W-1:0] exp_q[$];

  tone_decoder #(
    .GATE_CYCLES     (GATE),
    .MIN_EDGES       (4),
    .MAX_EDGES       (50),
    .CONFIRM_WINDOWS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bp1       (bpv[0]),
    .bp2       (bpv[1]),
    .bp3       (bpv[2]),
    .bp4       (bpv[3]),
    .bp5       (bpv[4]),
    .tdAck     (tdAck),
    .tdEn      (tdEn),
    .tdDir     (tdDir),
    .tdStop    (tdStop),
    .dbg_state (dbg_state)
  );

  // clock / cycle stamp
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // tone generators: period per[b] clk, 0 = silent
  initial begin
    for (int b = 0; b < 5; b++) begin per[b] = 0; ph[b] = 0; end
    forever begin
      @(negedge clk);
      for (int b = 0; b < 5; b++) begin
        if (per[b] == 0) begin
          bpv[b] = 1'b0;
          ph[b]  = 0;
        end else begin
          ph[b] = ph[b] + 1;
          if (ph[b] >= per[b] / 2) begin
            bpv[b] = ~bpv[b];
            ph[b]  = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    int guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) begin
      checks++;
      failures++;
      $display("FAIL wait_cyc: timed out at cyc %0d waiting for %0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int b = 0; b < 5; b++) per[b] = 0;
    tdAck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_cmd(input logic en, input logic stop, input logic [1:0] dir,
                            input int unsigned at);
    exp_q.push_back({en, stop, dir, at[19:0]});
  endtask

  task automatic pulse_ack_at(input int unsigned at);
    wait_cyc(at);
    tdAck = 1'b1;
    @(negedge clk);
    tdAck = 1'b0;
  endtask

  // monitor: every rising command must match the head of the expected queue
  initial begin
    logic         prev_act;
    logic         act;
    logic [W-1:0] got;
    logic [W-1:0] exp;
    prev_act = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_act = 1'b0;
      end else begin
        act = tdEn | tdStop;
        if (act && !prev_act) begin
          got = {tdEn, tdStop, tdDir, cyc[19:0]};
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_cmd: got en=%0b stop=%0b dir=%0b at cyc %0d, none expected",
                     tdEn, tdStop, tdDir, cyc);
          end else begin
            exp = exp_q.pop_front();
            chk("cmd_event", 32'(got), 32'(exp));
          end
        end
        prev_act = act;
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_tdEn", 32'(tdEn), 0);
    chk("rst_tdDir", 32'(tdDir), 0);
    chk("rst_tdStop", 32'(tdStop), 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // 1: bp3 for three windows -> RIGHT one clk after the third eval
    per[2] = 40;
    expect_cmd(1'b1, 1'b0, DIR_RIGHT, 3 * GATE);
    wait_cyc(3 * GATE - 1);
    chk("t1_not_early", 32'(tdEn), 0);
    wait_cyc(3 * GATE);
    chk("t1_state_valid", 32'(dbg_state), 32'(VALID));

    // 2: ack with tone still present, then silence, then tone again
    pulse_ack_at(3 * GATE + 5);
    chk("t2_en_drop", 32'(tdEn), 0);
    chk("t2_state_rearm", 32'(dbg_state), 32'(REARM));
    wait_cyc(5 * GATE);
    chk("t2_held_rearm", 32'(dbg_state), 32'(REARM));
    chk("t2_en_stays0", 32'(tdEn), 0);
    per[2] = 0;
    wait_cyc(6 * GATE + 1);
    chk("t2_idle_after_silence", 32'(dbg_state), 32'(IDLE));
    per[2] = 40;
    expect_cmd(1'b1, 1'b0, DIR_RIGHT, 9 * GATE);
    wait_cyc(9 * GATE + 2);

    // 3: bp2 two windows then bp4 three windows -> BACK only
    do_reset();
    per[1] = 40;
    wait_cyc(2 * GATE);
    per[1] = 0;
    per[3] = 40;
    expect_cmd(1'b1, 1'b0, DIR_BACK, 5 * GATE);
    wait_cyc(5 * GATE + 2);

    // 4: ambiguous, too few and too many edges never confirm
    do_reset();
    per[0] = 40;
    per[1] = 40;
    wait_cyc(4 * GATE + 1);
    chk("t4_ambig_idle", 32'(dbg_state), 32'(IDLE));
    per[1] = 0;
    per[0] = 1000;
    wait_cyc(7 * GATE + 1);
    chk("t4_sparse_idle", 32'(dbg_state), 32'(IDLE));
    per[0] = 10;
    wait_cyc(10 * GATE + 1);
    chk("t4_dense_idle", 32'(dbg_state), 32'(IDLE));
    chk("t4_en0", 32'(tdEn), 0);

    // 5: stop tone, then ack coincident with eval
    do_reset();
    per[4] = 40;
    expect_cmd(1'b0, 1'b1, DIR_STRAIGHT, 3 * GATE);
    wait_cyc(4 * GATE - 1);
    chk("t5_stop_held", 32'(tdStop), 1);
    tdAck = 1'b1;
    @(negedge clk);
    tdAck = 1'b0;
    per[4] = 0;
    chk("t5_stop_drop", 32'(tdStop), 0);
    chk("t5_state_rearm", 32'(dbg_state), 32'(REARM));
    wait_cyc(5 * GATE + 1);
    chk("t5_idle_after_full_window", 32'(dbg_state), 32'(IDLE));

    // 6: async reset mid-confirm, then three fresh windows
    do_reset();
    per[0] = 40;
    wait_cyc(2 * GATE + 500);
    chk("t6_mid_confirm", 32'(dbg_state), 32'(CONFIRM));
    #2 rst = 1'b1;
    #1;
    chk("t6_async_state", 32'(dbg_state), 32'(IDLE));
    chk("t6_async_en", 32'(tdEn), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    expect_cmd(1'b1, 1'b0, DIR_STRAIGHT, 3 * GATE);
    wait_cyc(3 * GATE - 1);
    chk("t6_not_early", 32'(tdEn), 0);
    wait_cyc(3 * GATE + 2);

    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
